// File: rtl/ofm_pkg.sv
// Shared types and constants for the OFM word packer.
package ofm_pkg;

   typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

   localparam int         BYTES_PER_WORD = 4;
   localparam logic [7:0] PAD_BYTE       = 8'h00;

   typedef logic [1:0] lane_t;

   // Negative values (bit 7 set) are clamped to zero.
   function automatic logic [7:0] relu8(input logic [7:0] b);
      return b[7] ? PAD_BYTE : b;
   endfunction

endpackage

// File: rtl/ofm_lane_reg.sv
// 32-bit word register with per-lane byte write and synchronous clear.
// Build option OFM_PACK_RELU_EN clamps negative input bytes to zero before they are stored.
module ofm_lane_reg
   import ofm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        wr_en,
   input  lane_t       lane,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic [31:0] word_next
);

   logic [7:0]  pack_byte;
   logic [31:0] word_reg;

`ifdef OFM_PACK_RELU_EN
   assign pack_byte = relu8(din);
`else
   assign pack_byte = din;
`endif

   // Lane 0 is the most significant byte so the OFM read side sees bytes in arrival order.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         assign word_next[31 - 8*gi -: 8] =
            (wr_en && (lane == lane_t'(gi))) ? pack_byte : word_reg[31 - 8*gi -: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         word_reg <= '0;
      else if (clr)
         word_reg <= {BYTES_PER_WORD{PAD_BYTE}};
      else
         word_reg <= word_next;
   end

   assign word = word_reg;

endmodule

// File: rtl/ofm_word_packer.sv
// Packs the output-feature byte stream into 32-bit OFM words and pulses mem_done after the frame.
// Build option OFM_PACK_RELU_EN enables ReLU on incoming bytes (see ofm_lane_reg).
module ofm_word_packer
   import ofm_pkg::*;
#(
   parameter int SIZE      = 128,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [31:0]       mem_datai,
   output logic              mem_done,
   output logic              busy,
   output logic              overflow
);

   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] FINAL_ADDR = ADDR_W'(BASE_ADDR + SIZE - 1);

   state_t              state_reg;
   lane_t               byte_idx_reg;
   logic [ADDR_W-1:0]   word_addr_reg;
   logic                last_reg;
   logic                in_ready_reg;
   logic                mem_we_reg;
   logic [ADDR_W-1:0]   mem_write_addr_reg;
   logic [31:0]         mem_datai_reg;
   logic                mem_done_reg;
   logic                busy_reg;
   logic                overflow_reg;

   logic                accept;
   logic                lane_clr;
   logic [31:0]         word;
   logic [31:0]         word_next;

   assign accept   = in_valid && in_ready_reg;
   assign lane_clr = ((state_reg == IDLE) && start) || (state_reg == WRITE);

   ofm_lane_reg u_lane_reg (
      .clk       (clk),
      .rst       (rst),
      .clr       (lane_clr),
      .wr_en     (accept),
      .lane      (byte_idx_reg),
      .din       (in_data),
      .word      (word),
      .word_next (word_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg          <= IDLE;
         byte_idx_reg       <= '0;
         word_addr_reg      <= FIRST_ADDR;
         last_reg           <= 1'b0;
         in_ready_reg       <= 1'b0;
         mem_we_reg         <= 1'b0;
         mem_write_addr_reg <= '0;
         mem_datai_reg      <= '0;
         mem_done_reg       <= 1'b0;
         busy_reg           <= 1'b0;
         overflow_reg       <= 1'b0;
      end else begin
         mem_we_reg   <= 1'b0;
         mem_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  overflow_reg  <= 1'b0;
                  word_addr_reg <= FIRST_ADDR;
                  byte_idx_reg  <= '0;
                  last_reg      <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b1;
                  state_reg     <= PACK;
               end
            end
            PACK: begin
               if (accept) begin
                  byte_idx_reg <= byte_idx_reg + lane_t'(1);
                  if (byte_idx_reg == lane_t'(BYTES_PER_WORD - 1) || in_last) begin
                     // Word is presented from word_next so the write lands one cycle after acceptance.
                     last_reg           <= in_last;
                     in_ready_reg       <= 1'b0;
                     mem_we_reg         <= 1'b1;
                     mem_write_addr_reg <= word_addr_reg;
                     mem_datai_reg      <= word_next;
                     state_reg          <= WRITE;
                  end
               end
            end
            WRITE: begin
               byte_idx_reg  <= '0;
               word_addr_reg <= word_addr_reg + ADDR_W'(1);
               if (last_reg) begin
                  mem_done_reg <= 1'b1;
                  state_reg    <= DONE;
               end else if (word_addr_reg == FINAL_ADDR) begin
                  overflow_reg <= 1'b1;
                  mem_done_reg <= 1'b1;
                  state_reg    <= DONE;
               end else begin
                  in_ready_reg <= 1'b1;
                  state_reg    <= PACK;
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign in_ready       = in_ready_reg;
   assign mem_we         = mem_we_reg;
   assign mem_write_addr = mem_write_addr_reg;
   assign mem_datai      = mem_datai_reg;
   assign mem_done       = mem_done_reg;
   assign busy           = busy_reg;
   assign overflow       = overflow_reg;

endmodule

// File: tb/tb_ofm_word_packer.sv
// Scoreboard bench for ofm_word_packer: expected writes are queued as bytes are driven and popped on mem_we.
module tb_ofm_word_packer;

   localparam int SIZE_TB = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_write_addr;
   logic [31:0] mem_datai;
   logic        mem_done;
   logic        busy;
   logic        overflow;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int done_cnt = 0;

   logic [39:0] sb[$];
   logic [7:0]  frame_q[$];

   ofm_word_packer #(.SIZE(SIZE_TB), .ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .mem_we         (mem_we),
      .mem_write_addr (mem_write_addr),
      .mem_datai      (mem_datai),
      .mem_done       (mem_done),
      .busy           (busy),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [7:0] b);
`ifdef OFM_PACK_RELU_EN
      return b[7] ? 8'h00 : b;
`else
      return b;
`endif
   endfunction

   // Write monitor: one line per OFM write.
   always @(negedge clk) begin
      logic [39:0] e;
      if (rst) check("we_done_excl", {63'd0, mem_we & mem_done}, 64'd0);
      if (mem_we) begin
         $display("WRITE addr=%0d data=%08h", mem_write_addr, mem_datai);
         check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("waddr", 64'(mem_write_addr), 64'(e[39:32]));
            check("wdata", 64'(mem_datai), 64'(e[31:0]));
         end
         last_we_cyc = cyc;
      end
      if (mem_done) begin
         check("done_lat", 64'(cyc - last_we_cyc), 64'd1);
         done_cnt++;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l, input int gap, output bit ok);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (in_ready) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Drives frame_q and predicts every word, including the overflow cutoff.
   task automatic send_frame(input bit use_last, input int max_gap);
      logic [31:0] w = '0;
      int lane = 0;
      int addr = 0;
      bit ovf = 1'b0;
      bit ok;
      bit l;
      int gap;
      for (int i = 0; i < frame_q.size(); i++) begin
         l = use_last && (i == frame_q.size() - 1);
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         if (!ovf) begin
            w[31 - 8*lane -: 8] = model_byte(frame_q[i]);
            lane++;
            if (lane == 4 || l) begin
               sb.push_back({8'(addr), w});
               w = '0;
               lane = 0;
               if (!l && addr == SIZE_TB - 1) ovf = 1'b1;
               addr++;
            end
            send_byte(frame_q[i], l, gap, ok);
            check("byte_accept", {63'd0, ok}, 64'd1);
         end else begin
            send_byte(frame_q[i], l, gap, ok);
            check("ovf_reject", {63'd0, ok}, 64'd0);
         end
      end
   endtask

   task automatic expect_done(input int prev);
      for (int c = 0; c < 20; c++) begin
         if (done_cnt > prev) break;
         @(negedge clk);
         #1;
      end
      check("done_count", 64'(done_cnt), 64'(prev + 1));
      @(negedge clk);
      #1;
      check("busy_fall", {63'd0, busy}, 64'd0);
   endtask

   task automatic load(input logic [7:0] first, input int n);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(first + 8'(i));
   endtask

   initial begin
      int prev;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_we", {63'd0, mem_we}, 64'd0);
      check("rst_done", {63'd0, mem_done}, 64'd0);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      check("rst_data", 64'(mem_datai), 64'd0);
      check("rst_addr", 64'(mem_write_addr), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Eight bytes back to back, last on the eighth.
      prev = done_cnt;
      pulse_start();
      check("busy_up", {63'd0, busy}, 64'd1);
      load(8'h01, 8);
      send_frame(1'b1, 0);
      expect_done(prev);

      // Five bytes: partial second word padded with zeros; a start mid-frame is ignored.
      prev = done_cnt;
      pulse_start();
      load(8'h01, 5);
      begin
         bit ok;
         sb.push_back({8'd0, 32'h01020304});
         send_byte(8'h01, 1'b0, 0, ok);
         check("byte_accept", {63'd0, ok}, 64'd1);
         pulse_start();
         for (int i = 1; i < 4; i++) begin
            send_byte(8'(i + 1), 1'b0, 0, ok);
            check("byte_accept", {63'd0, ok}, 64'd1);
         end
         sb.push_back({8'd1, 32'h05000000});
         send_byte(8'h05, 1'b1, 0, ok);
         check("byte_accept", {63'd0, ok}, 64'd1);
      end
      expect_done(prev);

      // Random gaps on in_valid.
      prev = done_cnt;
      pulse_start();
      load(8'h01, 8);
      send_frame(1'b1, 3);
      expect_done(prev);

      // Overflow: twelve bytes without last into a two-word OFM.
      prev = done_cnt;
      pulse_start();
      load(8'h10, 12);
      send_frame(1'b0, 0);
      expect_done(prev);
      check("ovf_set", {63'd0, overflow}, 64'd1);
      check("ovf_ready", {63'd0, in_ready}, 64'd0);
      prev = done_cnt;
      pulse_start();
      check("ovf_clear", {63'd0, overflow}, 64'd0);
      frame_q.delete();
      frame_q.push_back(8'h25);
      send_frame(1'b1, 0);
      expect_done(prev);

      // Asynchronous reset mid-frame.
      prev = done_cnt;
      pulse_start();
      load(8'h31, 6);
      send_frame(1'b0, 0);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_ready", {63'd0, in_ready}, 64'd0);
      check("arst_we", {63'd0, mem_we}, 64'd0);
      check("arst_data", 64'(mem_datai), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("arst_no_done", 64'(done_cnt), 64'(prev));
      pulse_start();
      load(8'hC1, 4);
      send_frame(1'b1, 0);
      expect_done(prev);

      // ReLU pattern.
      prev = done_cnt;
      pulse_start();
      frame_q.delete();
      frame_q.push_back(8'h80);
      frame_q.push_back(8'h7F);
      frame_q.push_back(8'hFF);
      frame_q.push_back(8'h01);
`ifdef OFM_PACK_RELU_EN
      check("relu_model", 64'({model_byte(8'h80), model_byte(8'h7F), model_byte(8'hFF), model_byte(8'h01)}), 64'h007F0001);
`else
      check("relu_model", 64'({model_byte(8'h80), model_byte(8'h7F), model_byte(8'hFF), model_byte(8'h01)}), 64'h807FFF01);
`endif
      send_frame(1'b1, 0);
      expect_done(prev);

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ofm_word_packer.md
Name: ofm_word_packer

Overview:
- Upstream neighbour of the OFM memory. It takes the byte stream of output-feature values from the convolution datapath and packs every 4 bytes into one 32-bit word.
- It writes each word through the OFM write port (we, write_addr, datai) and pulses done after the last word, which triggers the OFM dump.
- Byte lane order matches the OFM read mapping: byte 0 of a word goes to [31:24], byte 3 to [7:0].

Parameters:
SIZE, 128, depth of the target OFM in 32-bit words; the write address wraps never, see overflow
ADDR_W, 8, width of mem_write_addr; SIZE <= 2**ADDR_W
BASE_ADDR, 0, first word address written after each start

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a new frame; ignored unless IDLE
in_valid  in  1  upstream byte valid
in_data  in  8  upstream byte
in_last  in  1  marks final byte of frame; qualified by in_valid & in_ready
in_ready  out  1  packer accepts a byte this cycle
mem_we  out  1  OFM write enable, one-cycle pulse per word
mem_write_addr  out  ADDR_W  OFM word address
mem_datai  out  32  packed word
mem_done  out  1  one-cycle pulse after final word is written
busy  out  1  high in any state other than IDLE
overflow  out  1  sticky; frame exceeded SIZE words; cleared by the next accepted start

Behaviour:
- Reset (rst low, async):
  - state=IDLE; all outputs 0; byte_idx=0; word_addr=BASE_ADDR; word register=0.
  - A reset mid-frame abandons the frame; no mem_done is issued.
- A byte is accepted on a rising edge where in_valid & in_ready. All outputs are registered.
- IDLE:
  - in_ready=0.
  - On start: overflow clears, word_addr=BASE_ADDR, byte_idx=0, word register cleared, go to PACK.
- PACK:
  - in_ready=1.
  - An accepted byte is written to lane byte_idx; lane 0 is [31:24]. byte_idx increments mod 4.
  - If byte_idx==3 or in_last, go to WRITE; the last flag is latched.
  - Unfilled lanes of a partial word stay 8'h00.
- WRITE (one cycle):
  - in_ready=0; mem_we=1; mem_write_addr=word_addr; mem_datai=word register.
  - Latency: mem_we is high in the cycle immediately after the edge that accepted the 4th or last byte.
  - On exit: word register clears, byte_idx=0, word_addr increments.
  - If last was latched: go to DONE.
  - Else if word_addr == BASE_ADDR+SIZE-1 (just written the final slot): overflow=1, go to DONE.
  - Else: go to PACK.
- DONE (one cycle): mem_done=1; in_ready=0; then IDLE.
- Throughput: 4 bytes per 5 cycles with continuous in_valid. Gaps in in_valid stall in PACK without loss.
- Boundary cases:
  - start while busy is ignored.
  - in_last on byte_idx==3 produces exactly one WRITE, not an extra empty word.
  - A frame with in_last on the first byte writes one word {byte,24'h0}.
  - After overflow, upstream bytes are not accepted; in_ready stays 0 until the next start.
  - mem_we and mem_done are never high in the same cycle.

Optional Feature:
- Macro: OFM_PACK_RELU_EN.
- When defined: in_data is treated as signed; bytes with bit 7 set are packed as 8'h00 (ReLU), all others pass unchanged.
- When undefined: bytes are packed verbatim.
- Timing and handshake are identical in both builds.

Decomposition:
- Package ofm_pkg holds:
  - state enum {IDLE, PACK, WRITE, DONE}
  - BYTES_PER_WORD=4
  - PAD_BYTE=8'h00
  - lane-index type (2 bits)
- One sub-module: ofm_lane_reg. It is the 32-bit word register with per-lane byte write, synchronous clear, and the optional ReLU applied at its input.

Test Plan:
- start, then bytes 01..08 back-to-back, in_last on 08:
  - writes 32'h01020304 @0, then 32'h05060708 @1
  - mem_done one cycle after the second mem_we; busy falls next cycle.
- Bytes 01..05, in_last on 05:
  - writes 01020304 @0, then 05000000 @1, then mem_done.
- Random in_valid gaps on the 8-byte frame: the same two words and addresses; no byte lost or duplicated.
- SIZE=2, 12 bytes without in_last:
  - writes at 0 and 1 only, then mem_done; overflow=1; in_ready stays 0.
  - The next start clears overflow.
- rst low after 6 bytes accepted:
  - outputs 0 asynchronously; no mem_done.
  - A new start writes from BASE_ADDR.
- With OFM_PACK_RELU_EN, bytes 80,7F,FF,01 with last:
  - writes 32'h007F0001.
  - Without the macro the same bytes write 32'h807FFF01.
